axi4lite_ni_fifo_slave: RTL and testbench
=========================================

# axi4lite_ni_fifo_slave

Parametrised AXI4-Lite slave front end for the network interface, giving a processor-side master access to NCH independent channel pairs: one TX FIFO (push) and one RX FIFO (pop) per channel. Adds full address decoding, per-channel status registers, independent AW/W acceptance, write-strobe checking and SLVERR/DECERR responses. Sits between the core's AXI4-Lite master port and the NI packetiser/depacketiser FIFOs.

## Interface
- ADDR_W, 8, AXI address width (must satisfy 2^(ADDR_W-3) >= NCH)
- DATA_W, 32, AXI data and FIFO word width (multiple of 8)
- NCH, 2, number of TX/RX channel pairs (1..16)
- aclk  in  1  single clock; all logic rising-edge
- arestn  in  1  asynchronous, active-low reset
- awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel
- wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel
- bresp/bvalid/bready  out/out/in  2/1/1  write response
- araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel
- rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  read data channel
- tx_wr_en  out  NCH  one-cycle push strobe per channel
- tx_wr_data  out  NCH*DATA_W  push data; channel i at [i*DATA_W +: DATA_W]
- tx_full  in  NCH  TX FIFO full flags
- rx_rd_en  out  NCH  one-cycle pop strobe per channel
- rx_rd_data  in  NCH*DATA_W  RX FIFO head word (first-word-fall-through, valid while !rx_empty)
- rx_empty  in  NCH  RX FIFO empty flags

## Operation
- Address decode: ch = addr[ADDR_W-1:3]; reg = addr[2] (0 = DATA, 1 = STATUS); addr[1:0] ignored.
- ch >= NCH -> DECERR, no FIFO strobe.
- Write DATA: wstrb must be all ones and tx_full[ch]=0 -> OKAY, push wdata; otherwise SLVERR, no push.
- Write STATUS -> SLVERR, no effect.
- Read DATA: rx_empty[ch]=0 -> OKAY, rdata = head word, pop; empty -> SLVERR, rdata = 0, no pop.
- Read STATUS -> OKAY, rdata = {0..., rx_empty[ch], tx_full[ch]} (bit1 rx_empty, bit0 tx_full).
- DECERR/SLVERR reads return rdata = 0.
- Write FSM: W_IDLE -> W_RESP -> W_IDLE.
  - In W_IDLE, AW and W are accepted independently; each beat is held internally once handshaken, and its ready drops until the FSM returns to W_IDLE.
  - When both beats are held (including both in the same cycle), the next edge evaluates decode and tx_full, enters W_RESP, drives bvalid=1/bresp, and pulses tx_wr_en[ch] for exactly that one cycle on OKAY.
  - W_RESP holds bvalid and bresp stable until bready=1, then returns to W_IDLE with both holds cleared.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - arready=1 only in R_IDLE.
  - On AR handshake, decode, rx_empty and rx_rd_data are sampled; next edge enters R_DATA with rvalid=1, rdata/rresp registered, and rx_rd_en[ch] pulsed for one cycle on an OKAY DATA read.
  - rdata and rresp stay stable while rvalid=1 and rready=0.
  - On rvalid&rready, return to R_IDLE.
- Read and write paths are fully independent; a concurrent push and pop on the same channel are legal.
- tx_wr_data carries the held wdata on every channel slice; only tx_wr_en qualifies it.

## Timing
- Reset (arestn=0, asynchronous): awready, wready, arready, bvalid, rvalid, tx_wr_en, rx_rd_en = 0; bresp, rresp, rdata = 0; holds cleared; FSMs in IDLE.
- awready, wready and arready first go high on the first aclk edge after arestn deasserts.
- Write latency: bvalid is high 1 cycle after the later of the AW/W handshakes. Minimum 2 cycles per write with bready tied high.
- Read latency: rvalid is high 1 cycle after the AR handshake. Minimum 2 cycles per read with rready tied high.
- The full/empty decision uses flags sampled at the deciding edge. The slave is the only pusher and popper, so the flags cannot turn against a decision already taken.
- Reset mid-transaction discards held beats and pending responses; no strobe is issued after reset asserts.

## Test plan
- NCH=2, write 0xDEADBEEF to 0x08 (ch1 DATA), wstrb=0xF, tx_full=0 -> tx_wr_en=2'b10 for 1 cycle, data slice 1 = 0xDEADBEEF, bresp=OKAY 1 cycle after handshake.
- W beat presented 3 cycles before AW -> wready drops after the W handshake; exactly one push occurs; bvalid follows the AW handshake by 1 cycle.
- Write with tx_full[0]=1, or with wstrb=0x7 -> bresp=SLVERR, no tx_wr_en. Write to 0x10 with NCH=2 -> DECERR.
- rx_empty[0]=0, head word 0x12345678, read 0x00 with rready low for 4 cycles -> rdata stable at 0x12345678, rresp=OKAY, rx_rd_en[0] pulses once. Repeat read with rx_empty=1 -> SLVERR, rdata=0.
- Read 0x0C (ch1 STATUS) with tx_full[1]=1, rx_empty[1]=1 -> rdata=0x3, OKAY. Concurrent write to ch1 completes independently.
- Assert arestn low while bvalid=1 and with an AW held -> all outputs 0 immediately; after release, no stray bvalid or strobe, and readies go high on the next edge.

Source files
------------

// File: rtl/axi4lite_ni_fifo_slave.sv
// AXI4-Lite slave giving a core access to NCH TX/RX FIFO channel pairs.
// Per channel: DATA register (push on write, pop on read) and read-only STATUS.
module axi4lite_ni_fifo_slave #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NCH    = 2
) (
  input  logic                  aclk,
  input  logic                  arestn,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [NCH-1:0]        tx_wr_en,
  output logic [NCH*DATA_W-1:0] tx_wr_data,
  input  logic [NCH-1:0]        tx_full,
  output logic [NCH-1:0]        rx_rd_en,
  input  logic [NCH*DATA_W-1:0] rx_rd_data,
  input  logic [NCH-1:0]        rx_empty
);

  localparam int              CH_W   = ADDR_W - 3;
  localparam logic [CH_W:0]   NCH_L  = (CH_W + 1)'(NCH);
  localparam logic [1:0]      OKAY   = 2'b00;
  localparam logic [1:0]      SLVERR = 2'b10;
  localparam logic [1:0]      DECERR = 2'b11;

  typedef enum logic { W_IDLE, W_RESP } wstate_t;
  typedef enum logic { R_IDLE, R_DATA } rstate_t;

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  logic                  live;
  logic                  aw_held, w_held;
  logic [ADDR_W-1:2]     awaddr_p0;
  logic [DATA_W-1:0]     wdata_p0;
  logic [DATA_W/8-1:0]   wstrb_p0;
  logic                  aw_hs, w_hs, w_go, ar_hs;
  logic [ADDR_W-1:2]     w_addr;
  logic [DATA_W/8-1:0]   w_strb;
  logic [CH_W-1:0]       w_ch, r_ch;
  logic                  w_full, r_full, r_empty;
  logic [DATA_W-1:0]     r_head, r_data_d;
  logic [1:0]            w_resp_d, r_resp_d;
  logic [NCH-1:0]        push_d, pop_d;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, awaddr[1:0], araddr[1:0]};
  assign tx_wr_data       = {NCH{wdata_p0}};

  // Handshakes, readies and FSM next state
  always_comb begin
    awready = live && (w_state == W_IDLE) && !aw_held;
    wready  = live && (w_state == W_IDLE) && !w_held;
    arready = live && (r_state == R_IDLE);
    bvalid  = (w_state == W_RESP);
    rvalid  = (r_state == R_DATA);
    aw_hs   = awvalid && awready;
    w_hs    = wvalid && wready;
    ar_hs   = arvalid && arready;
    w_go    = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    w_next  = w_state;
    r_next  = r_state;
    case (w_state)
      W_IDLE:  if (w_go) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Write decode: a beat arriving this cycle is used directly, otherwise the held copy
  always_comb begin
    w_addr   = aw_held ? awaddr_p0 : awaddr[ADDR_W-1:2];
    w_strb   = w_held ? wstrb_p0 : wstrb;
    w_ch     = w_addr[ADDR_W-1:3];
    w_full   = 1'b0;
    push_d   = '0;
    w_resp_d = OKAY;
    for (int i = 0; i < NCH; i++)
      if (w_ch == CH_W'(i)) w_full = tx_full[i];
    if ({1'b0, w_ch} >= NCH_L)
      w_resp_d = DECERR;
    else if (w_addr[2] || (w_strb != '1) || w_full)
      w_resp_d = SLVERR;
    else
      for (int i = 0; i < NCH; i++) push_d[i] = (w_ch == CH_W'(i));
  end

  // Read decode
  always_comb begin
    r_ch     = araddr[ADDR_W-1:3];
    r_full   = 1'b0;
    r_empty  = 1'b1;
    r_head   = '0;
    pop_d    = '0;
    r_resp_d = OKAY;
    r_data_d = '0;
    for (int i = 0; i < NCH; i++)
      if (r_ch == CH_W'(i)) begin
        r_full  = tx_full[i];
        r_empty = rx_empty[i];
        r_head  = rx_rd_data[i*DATA_W +: DATA_W];
      end
    if ({1'b0, r_ch} >= NCH_L)
      r_resp_d = DECERR;
    else if (araddr[2])
      r_data_d = DATA_W'({r_empty, r_full});
    else if (!r_empty) begin
      r_data_d = r_head;
      for (int i = 0; i < NCH; i++) pop_d[i] = (r_ch == CH_W'(i));
    end else
      r_resp_d = SLVERR;
  end

  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Stage p0: beat holds, write response and push strobe
  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      live      <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_p0 <= '0;
      wdata_p0  <= '0;
      wstrb_p0  <= '0;
      bresp     <= OKAY;
      tx_wr_en  <= '0;
    end else begin
      live     <= 1'b1;
      tx_wr_en <= '0;
      if (aw_hs) awaddr_p0 <= awaddr[ADDR_W-1:2];
      if (w_hs) begin
        wdata_p0 <= wdata;
        wstrb_p0 <= wstrb;
      end
      if (w_go) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bresp    <= w_resp_d;
        tx_wr_en <= push_d;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
    end
  end

  // Stage p0: read response, data and pop strobe
  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      rdata    <= '0;
      rresp    <= OKAY;
      rx_rd_en <= '0;
    end else begin
      rx_rd_en <= '0;
      if (ar_hs) begin
        rdata    <= r_data_d;
        rresp    <= r_resp_d;
        rx_rd_en <= pop_d;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_ni_fifo_slave.sv
// Self-checking bench for axi4lite_ni_fifo_slave: directed scenarios plus
// randomized concurrent read/write traffic against a rule-level reference model.
module tb_axi4lite_ni_fifo_slave;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int NCH    = 2;

  logic                  aclk = 1'b0;
  logic                  arestn;
  logic [ADDR_W-1:0]     awaddr, araddr;
  logic                  awvalid, awready, wvalid, wready, bvalid, bready;
  logic                  arvalid, arready, rvalid, rready;
  logic [DATA_W-1:0]     wdata, rdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [1:0]            bresp, rresp;
  logic [NCH-1:0]        tx_wr_en, tx_full, rx_rd_en, rx_empty;
  logic [NCH*DATA_W-1:0] tx_wr_data, rx_rd_data;

  int n_checks = 0;
  int n_fails  = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;

  axi4lite_ni_fifo_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCH(NCH)) dut (
    .aclk(aclk), .arestn(arestn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (|tx_wr_en) push_cnt++;
    if (|rx_rd_en) pop_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] model_wresp(input logic [7:0] a, input logic [3:0] s,
                                             input logic [NCH-1:0] full);
    int ch;
    ch = int'(a) / 8;
    if (ch >= NCH) return 2'b11;
    if (a[2]) return 2'b10;
    if (s != 4'hF || full[ch]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [7:0] a, input logic [NCH-1:0] full,
                                     input logic [NCH-1:0] empty, input logic [NCH*DATA_W-1:0] heads,
                                     output logic [1:0] r, output logic [31:0] d,
                                     output logic [NCH-1:0] pop);
    int ch;
    ch  = int'(a) / 8;
    pop = '0;
    if (ch >= NCH) begin r = 2'b11; d = 0; end
    else if (a[2]) begin r = 2'b00; d = 32'(2 * int'(empty[ch]) + int'(full[ch])); end
    else if (!empty[ch]) begin r = 2'b00; d = heads[ch*DATA_W +: DATA_W]; pop[ch] = 1'b1; end
    else begin r = 2'b10; d = 0; end
  endfunction

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] er;
    logic [NCH-1:0] epush;
    int pc0, cyc, ch;
    bit awd, wd, aw_s, w_s;
    er = model_wresp(addr, strb, tx_full);
    ch = int'(addr) / 8;
    for (int i = 0; i < NCH; i++) epush[i] = (er == 2'b00) && (i == ch);
    pc0 = push_cnt; awd = 0; wd = 0; cyc = 0;
    while (!(awd && wd) && cyc < 40) begin
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = !awd && (cyc >= aw_dly);
      wvalid  = !wd && (cyc >= w_dly);
      #1;
      aw_s = awvalid && awready;
      w_s  = wvalid && wready;
      @(posedge aclk); #1;
      awd |= aw_s; wd |= w_s; cyc++;
      if (awd != wd) begin
        n_checks++;
        if (bvalid !== 1'b0 || (awd && awready !== 1'b0) || (wd && wready !== 1'b0)) begin
          n_fails++;
          $display("FAIL wr_hold addr=%h: bvalid=%b awready=%b wready=%b, required 0 on bvalid and held ready",
                   addr, bvalid, awready, wready);
        end
      end
    end
    awvalid = 0; wvalid = 0;
    n_checks++;
    if (!(awd && wd)) begin
      n_fails++;
      $display("FAIL wr_timeout addr=%h: aw_done=%b w_done=%b, required both", addr, awd, wd);
      return;
    end
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== er) begin
      n_fails++;
      $display("FAIL wr_resp addr=%h strb=%h: bvalid=%b bresp=%b, required 1/%b", addr, strb, bvalid, bresp, er);
    end
    n_checks++;
    if (tx_wr_en !== epush) begin
      n_fails++;
      $display("FAIL wr_strobe addr=%h: tx_wr_en=%b, required %b", addr, tx_wr_en, epush);
    end
    if (er == 2'b00) begin
      n_checks++;
      if (tx_wr_data[ch*DATA_W +: DATA_W] !== data) begin
        n_fails++;
        $display("FAIL wr_data ch=%0d: %h, required %h", ch, tx_wr_data[ch*DATA_W +: DATA_W], data);
      end
    end
    for (int i = 0; i < b_dly; i++) begin
      @(posedge aclk); #1;
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== er || tx_wr_en !== '0) begin
        n_fails++;
        $display("FAIL wr_stable addr=%h: bvalid=%b bresp=%b tx_wr_en=%b, required 1/%b/0",
                 addr, bvalid, bresp, tx_wr_en, er);
      end
    end
    bready = 1; @(posedge aclk); #1; bready = 0;
    n_checks++;
    if (bvalid !== 1'b0 || (push_cnt - pc0) != ((er == 2'b00) ? 1 : 0)) begin
      n_fails++;
      $display("FAIL wr_done addr=%h: bvalid=%b pushes=%0d, required 0/%0d",
               addr, bvalid, push_cnt - pc0, (er == 2'b00) ? 1 : 0);
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input int r_dly);
    logic [1:0] er;
    logic [31:0] ed;
    logic [NCH-1:0] epop;
    int pc0, cyc;
    bit hs;
    model_read(addr, tx_full, rx_empty, rx_rd_data, er, ed, epop);
    pc0 = pop_cnt; cyc = 0; hs = 0;
    while (!hs && cyc < 40) begin
      araddr = addr; arvalid = 1;
      #1; hs = arready;
      @(posedge aclk); #1; cyc++;
    end
    arvalid = 0;
    n_checks++;
    if (!hs) begin
      n_fails++;
      $display("FAIL rd_timeout addr=%h: arready never seen", addr);
      return;
    end
    for (int i = 0; i < NCH; i++)
      if (epop[i]) rx_rd_data[i*DATA_W +: DATA_W] = $urandom;
    n_checks++;
    if (rvalid !== 1'b1 || rresp !== er || rdata !== ed || rx_rd_en !== epop) begin
      n_fails++;
      $display("FAIL rd_resp addr=%h: rvalid=%b rresp=%b rdata=%h rx_rd_en=%b, required 1/%b/%h/%b",
               addr, rvalid, rresp, rdata, rx_rd_en, er, ed, epop);
    end
    for (int i = 0; i < r_dly; i++) begin
      @(posedge aclk); #1;
      n_checks++;
      if (rvalid !== 1'b1 || rresp !== er || rdata !== ed || rx_rd_en !== '0) begin
        n_fails++;
        $display("FAIL rd_stable addr=%h: rvalid=%b rresp=%b rdata=%h rx_rd_en=%b, required 1/%b/%h/0",
                 addr, rvalid, rresp, rdata, rx_rd_en, er, ed);
      end
    end
    rready = 1; @(posedge aclk); #1; rready = 0;
    n_checks++;
    if (rvalid !== 1'b0 || (pop_cnt - pc0) != ((|epop) ? 1 : 0)) begin
      n_fails++;
      $display("FAIL rd_done addr=%h: rvalid=%b pops=%0d, required 0/%0d",
               addr, rvalid, pop_cnt - pc0, (|epop) ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    arestn = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0; tx_full = 0; rx_empty = '1; rx_rd_data = 0;
    #1;
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid, tx_wr_en, rx_rd_en, bresp, rresp, rdata} !== '0) begin
      n_fails++;
      $display("FAIL reset_state: rdy=%b%b%b bvalid=%b rvalid=%b rdata=%h, required all 0",
               awready, wready, arready, bvalid, rvalid, rdata);
    end
    repeat (3) @(posedge aclk);
    #1 arestn = 1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_fails++;
      $display("FAIL reset_release_early: readies=%b, required 000", {awready, wready, arready});
    end
    @(posedge aclk); #1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fails++;
      $display("FAIL reset_release_edge: readies=%b, required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_basic();
    tx_full = 0;
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_write(8'h01, 32'h0BAD_CAFE, 4'hF, 0, 0, 2);
  endtask

  task automatic test_w_before_aw();
    tx_full = 0;
    do_write(8'h00, $urandom, 4'hF, 3, 0, 1);
    do_write(8'h0B, $urandom, 4'hF, 0, 2, 0);
  endtask

  task automatic test_write_errors();
    tx_full = 2'b01;
    do_write(8'h00, 32'h1111_1111, 4'hF, 0, 0, 0);
    tx_full = 2'b00;
    do_write(8'h08, 32'h2222_2222, 4'h7, 0, 0, 1);
    do_write(8'h10, 32'h3333_3333, 4'hF, 0, 0, 0);
    do_write(8'h04, 32'h4444_4444, 4'hF, 1, 0, 0);
  endtask

  task automatic test_read_data();
    tx_full = 0; rx_empty = 2'b10;
    rx_rd_data[DATA_W-1:0] = 32'h12345678;
    do_read(8'h00, 4);
    rx_empty = 2'b11;
    do_read(8'h00, 0);
    do_read(8'h18, 1);
  endtask

  task automatic test_status_concurrent();
    tx_full = 2'b10; rx_empty = 2'b10;
    fork
      do_read(8'h0C, 2);
      do_write(8'h08, 32'h5555_AAAA, 4'hF, 1, 0, 1);
    join
    tx_full = 2'b00; rx_empty = 2'b00;
    rx_rd_data = {$urandom, $urandom};
    fork
      do_read(8'h00, 0);
      do_write(8'h00, 32'h6666_7777, 4'hF, 0, 0, 0);
    join
  endtask

  task automatic test_back_to_back();
    tx_full = 0; rx_empty = 0;
    for (int i = 0; i < 4; i++) begin
      rx_rd_data = {$urandom, $urandom};
      fork
        do_write(8'((i % 2) * 8), $urandom, 4'hF, 0, 0, 0);
        do_read(8'((i % 2) * 8), 0);
      join
    end
  endtask

  task automatic test_random();
    logic [7:0] wa, ra;
    logic [3:0] ws;
    for (int it = 0; it < 40; it++) begin
      tx_full    = NCH'($urandom);
      rx_empty   = NCH'($urandom);
      rx_rd_data = {$urandom, $urandom};
      wa = 8'($urandom_range(0, 31));
      ra = 8'($urandom_range(0, 31));
      ws = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      fork
        do_write(wa, $urandom, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        do_read(ra, $urandom_range(0, 2));
      join
    end
  endtask

  task automatic test_reset_mid();
    int pc0;
    bit seen;
    tx_full = 0; rx_empty = '1;
    awaddr = 8'h08; awvalid = 1; wdata = 32'hA5A5_0001; wstrb = 4'hF; wvalid = 1;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    n_checks++;
    if (bvalid !== 1'b1 || tx_wr_en !== 2'b10) begin
      n_fails++;
      $display("FAIL rst_pre: bvalid=%b tx_wr_en=%b, required 1/10", bvalid, tx_wr_en);
    end
    #2 arestn = 0;
    #1;
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid, tx_wr_en, rx_rd_en, bresp, rresp, rdata} !== '0) begin
      n_fails++;
      $display("FAIL rst_async: rdy=%b%b%b bvalid=%b tx_wr_en=%b rdata=%h, required all 0",
               awready, wready, arready, bvalid, tx_wr_en, rdata);
    end
    @(posedge aclk); #1 arestn = 1;
    n_checks++;
    if ({awready, wready, arready, bvalid} !== 4'b0000) begin
      n_fails++;
      $display("FAIL rst_mid_release: rdy=%b bvalid=%b, required 000/0", {awready, wready, arready}, bvalid);
    end
    @(posedge aclk); #1;
    n_checks++;
    if ({awready, wready, arready, bvalid, tx_wr_en} !== {3'b111, 1'b0, 2'b00}) begin
      n_fails++;
      $display("FAIL rst_mid_edge: rdy=%b bvalid=%b tx_wr_en=%b, required 111/0/00",
               {awready, wready, arready}, bvalid, tx_wr_en);
    end
    pc0 = push_cnt;
    awaddr = 8'h00; awvalid = 1;
    @(posedge aclk); #1;
    awvalid = 0;
    arestn = 0; #2 arestn = 1;
    @(posedge aclk); #1;
    wdata = 32'h0000_BEEF; wvalid = 1;
    @(posedge aclk); #1;
    wvalid = 0;
    n_checks++;
    if (wready !== 1'b0 || awready !== 1'b1) begin
      n_fails++;
      $display("FAIL rst_hold_clear: wready=%b awready=%b, required 0/1", wready, awready);
    end
    seen = 0;
    repeat (4) begin
      @(posedge aclk); #1;
      seen |= bvalid;
    end
    n_checks++;
    if (seen || push_cnt != pc0) begin
      n_fails++;
      $display("FAIL rst_no_stray: bvalid_seen=%b pushes=%0d, required 0/0", seen, push_cnt - pc0);
    end
    arestn = 0; #2 arestn = 1;
    @(posedge aclk); #1;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_w_before_aw();
    test_write_errors();
    test_read_data();
    test_status_concurrent();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
